inv_div_scheduler: RTL and testbench

- Sequential controller for the final stage of the 4x4 matrix inverse: each of the 16 adjugate entries is divided by the determinant.
- Replaces the sixteen parallel divider instances with one shared, multi-cycle divider reached through a valid/ready request channel and a response-valid channel.
- On start it captures the adjugate and determinant, then issues 16 divisions in row-major order.
- Results are collected into a registered 4x4 output bank, with a done pulse and a singular flag.

---
 rtl/inv_pkg.sv | 21 ++
 rtl/inv_div_scheduler.sv | 90 +++++++++
 tb/tb_inv_div_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/inv_pkg.sv
// Shared constants, FSM state type and the IEEE-754 zero test used by the
// matrix-inverse divide scheduler.
package inv_pkg;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int IW = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FIN
    } state_t;

    // Sign bit ignored so that both +0 and -0 count as zero.
    function automatic logic is_zero_f32(input logic [DW-1:0] word);
        return (word[30:0] == 31'd0);
    endfunction

endpackage

// File: rtl/inv_div_scheduler.sv
// Sequences the 16 adjugate/determinant divisions of a 4x4 inverse through
// one shared multi-cycle divider and collects the quotients in a result bank.
module inv_div_scheduler
    import inv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*DW-1:0]   adj_in,
    input  logic [DW-1:0]     det_in,
    output logic              busy,
    output logic              done,
    output logic              singular,
    output logic [N*DW-1:0]   inv_out,
    output logic              div_req_valid,
    input  logic              div_req_ready,
    output logic [DW-1:0]     div_num,
    output logic [DW-1:0]     div_den,
    output logic [IW-1:0]     div_tag,
    input  logic              div_rsp_valid,
    input  logic [DW-1:0]     div_rsp_data
);

    state_t               state, state_nx;
    logic [IW-1:0]        idx;
    logic [N-1:0][DW-1:0] adj_q;
    logic [N-1:0][DW-1:0] inv_q;
    logic [DW-1:0]        det_q;
    logic                 last;

    assign last = (idx == IW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = is_zero_f32(det_in) ? FIN : REQ;
            REQ:  if (div_req_ready) state_nx = WAIT;
            WAIT: if (div_rsp_valid) state_nx = last ? FIN : REQ;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request channel is decoded from the state register so it falls with rst_n.
    assign div_req_valid = (state == REQ);
    assign div_num       = adj_q[idx];
    assign div_den       = det_q;
    assign div_tag       = idx;
    assign inv_out       = inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_q    <= '0;
            det_q    <= '0;
            inv_q    <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            singular <= 1'b0;
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        adj_q    <= adj_in;
                        det_q    <= det_in;
                        idx      <= '0;
                        busy     <= 1'b1;
                        singular <= is_zero_f32(det_in);
                        if (is_zero_f32(det_in)) inv_q <= '0;
                    end
                end
                WAIT: begin
                    if (div_rsp_valid) begin
                        inv_q[idx] <= div_rsp_data;
                        if (!last) idx <= idx + 1'b1;
                    end
                end
                FIN:  busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_div_scheduler.sv
// Bench for inv_div_scheduler: a behavioural divider with configurable latency
// and per-tag backpressure, a table of directed runs plus random runs.
module tb_inv_div_scheduler;
    import inv_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [N*DW-1:0] adj_in = '0;
    logic [DW-1:0]   det_in = '0;
    logic            busy, done, singular;
    logic [N*DW-1:0] inv_out;
    logic            div_req_valid, div_req_ready;
    logic [DW-1:0]   div_num, div_den;
    logic [IW-1:0]   div_tag;
    logic            div_rsp_valid;
    logic [DW-1:0]   div_rsp_data;

    always #5 clk = ~clk;

    inv_div_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .adj_in(adj_in), .det_in(det_in),
        .busy(busy), .done(done), .singular(singular), .inv_out(inv_out),
        .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
        .div_num(div_num), .div_den(div_den), .div_tag(div_tag),
        .div_rsp_valid(div_rsp_valid), .div_rsp_data(div_rsp_data)
    );

    int errors = 0;
    int checks = 0;

    // Stand-in quotient: exact halving for det=2.0, otherwise an arbitrary
    // but data-dependent mix so misplaced or stale words show up.
    function automatic logic [DW-1:0] qmodel(input logic [DW-1:0] a, input logic [DW-1:0] d);
        if (d == 32'h40000000) return a - 32'h00800000;
        return a ^ {d[15:0], d[31:16]};
    endfunction

    // ---------------- divider model ----------------
    int            lat = 3;
    int            stall_tbl[N];
    int            wcnt, rcnt;
    logic          bfm_vld;
    logic [DW-1:0] bfm_data, q_hold;
    logic          spur_vld = 1'b0;
    logic [DW-1:0] spur_data = 32'hDEADBEEF;

    always_comb div_req_ready = div_req_valid && (wcnt >= stall_tbl[div_tag]);
    assign div_rsp_valid = bfm_vld | spur_vld;
    assign div_rsp_data  = spur_vld ? spur_data : bfm_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0; rcnt <= 0; bfm_vld <= 1'b0; bfm_data <= '0; q_hold <= '0;
        end else begin
            bfm_vld <= 1'b0;
            if (div_req_valid && !div_req_ready) wcnt <= wcnt + 1;
            if (div_req_valid && div_req_ready) begin
                wcnt <= 0;
                if (lat <= 1) begin
                    bfm_vld <= 1'b1; bfm_data <= qmodel(div_num, div_den);
                end else begin
                    rcnt <= lat - 1; q_hold <= qmodel(div_num, div_den);
                end
            end else if (rcnt > 0) begin
                rcnt <= rcnt - 1;
                if (rcnt == 1) begin bfm_vld <= 1'b1; bfm_data <= q_hold; end
            end
        end
    end

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            tags_q[$];
    int            done_cnt = 0, stab_err = 0, vld_cnt = 0;
    logic          pend = 1'b0;
    logic [DW-1:0] p_num, p_den;
    logic [IW-1:0] p_tag;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (div_req_valid) vld_cnt <= vld_cnt + 1;
        if (pend && rst_n && (!div_req_valid || div_num != p_num || div_den != p_den || div_tag != p_tag))
            stab_err <= stab_err + 1;
        pend  <= div_req_valid && !div_req_ready;
        p_num <= div_num; p_den <= div_den; p_tag <= div_tag;
        if (div_req_valid && div_req_ready) tags_q.push_back(int'(div_tag));
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete run from start to done, checked against the reference model.
    task automatic run(input string nm, input logic [N*DW-1:0] a, input logic [DW-1:0] d,
                       input int l, input int s0, input int s7, input int rmax,
                       input bit restart, input bit spur, input int exp_lat_in);
        int tb, db, vb, sb, got, busy_bad, spur_bad, tag_bad, exp_lat, exp_vld;
        bit sing, snap_pend;
        logic [N*DW-1:0] snap;
        lat = l;
        for (int k = 0; k < N; k++) stall_tbl[k] = (rmax > 0) ? int'($urandom_range(rmax, 0)) : 0;
        if (s0 > 0) stall_tbl[0] = s0;
        if (s7 > 0) stall_tbl[7] = s7;
        sing = (d[30:0] == 31'd0);
        exp_vld = 0;
        for (int k = 0; k < N; k++) exp_vld += stall_tbl[k] + 1;
        exp_lat = 2 + exp_vld + N * l;
        if (sing) begin exp_lat = 2; exp_vld = 0; end
        if (exp_lat_in > 0) exp_lat = exp_lat_in;
        tb = tags_q.size(); db = done_cnt; vb = vld_cnt; sb = stab_err;
        got = -1; busy_bad = 0; spur_bad = 0; snap_pend = 0; snap = '0;
        @(posedge clk); #2;
        adj_in = a; det_in = d; start = 1'b1;
        for (int c = 1; c <= 3000 && got < 0; c++) begin
            @(posedge clk); #2;
            start = 1'b0; spur_vld = 1'b0;
            if (restart && c == 10) begin
                start = 1'b1; adj_in = ~a; det_in = d ^ 32'h00400000;
            end
            if (spur && div_req_valid) spur_vld = 1'b1;
            @(negedge clk);
            if (snap_pend && inv_out !== snap) spur_bad++;
            snap_pend = spur_vld; snap = inv_out;
            if (done) begin
                got = c;
                if (busy) busy_bad++;
            end else if (!busy) busy_bad++;
        end
        @(posedge clk); #2;
        spur_vld = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk({nm, " start-to-done"}, got, exp_lat);
        chk({nm, " done pulses"}, done_cnt - db, 1);
        chk({nm, " singular"}, singular, sing);
        chk({nm, " busy window"}, busy_bad, 0);
        chk({nm, " req valid cycles"}, vld_cnt - vb, exp_vld);
        chk({nm, " req count"}, tags_q.size() - tb, sing ? 0 : N);
        tag_bad = 0;
        for (int k = tb; k < tags_q.size(); k++) if (tags_q[k] != k - tb) tag_bad++;
        chk({nm, " tag order"}, tag_bad, 0);
        chk({nm, " req stable under stall"}, stab_err - sb, 0);
        if (spur) chk({nm, " spurious rsp in REQ"}, spur_bad, 0);
        for (int k = 0; k < N; k++)
            chk($sformatf("%s inv[%0d]", nm, k), inv_out[k*DW +: DW],
                sing ? 32'h0 : qmodel(a[k*DW +: DW], d));
    endtask

    typedef struct {
        bit          rnd_adj;
        logic [31:0] det;
        int          l, s0, s7;
        bit          restart, spur;
        int          exp_lat;
    } vec_t;

    vec_t            vt[7];
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] snap0;
    logic [DW-1:0]   d;
    int              tb0;
    bit              hit;

    initial begin
        vt[0] = '{0, 32'h40000000, 3, 0, 0, 0, 0, 66};
        vt[1] = '{1, 32'h80000000, 3, 0, 0, 0, 0, 2};
        vt[2] = '{1, 32'h3FC00000, 3, 5, 5, 0, 0, 76};
        vt[3] = '{1, 32'h41200000, 2, 0, 0, 1, 0, 50};
        vt[4] = '{1, 32'hC0400000, 4, 0, 0, 0, 1, 82};
        vt[5] = '{1, 32'h00000001, 1, 0, 0, 0, 0, 34};
        vt[6] = '{1, 32'h00000000, 2, 0, 0, 0, 0, 2};

        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset singular", singular, 0);
        chk("reset req_valid", div_req_valid, 0);
        chk("reset inv_out", inv_out, '0);
        chk("reset tag", div_tag, 0);
        #21 rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < N; k++) a[k*DW +: DW] = vt[v].rnd_adj ? $urandom : 32'h3F800000;
            run($sformatf("vec%0d", v), a, vt[v].det, vt[v].l, vt[v].s0, vt[v].s7, 0,
                vt[v].restart, vt[v].spur, vt[v].exp_lat);
            if (v == 4) begin
                // Response while IDLE must leave the bank untouched.
                @(posedge clk); #2;
                snap0 = inv_out; spur_vld = 1'b1;
                @(posedge clk); #2;
                spur_vld = 1'b0;
                @(negedge clk);
                chk("spurious rsp in IDLE", inv_out, snap0);
            end
        end

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) a[k*DW +: DW] = $urandom;
            d = $urandom;
            run($sformatf("rand%0d", r), a, d, int'($urandom_range(5, 1)), 0, 0, 3, 0, 0, -1);
        end

        // Reset while waiting on element 5's quotient.
        for (int k = 0; k < N; k++) a[k*DW +: DW] = $urandom | 32'h1;
        lat = 3;
        for (int k = 0; k < N; k++) stall_tbl[k] = 0;
        tb0 = tags_q.size();
        @(posedge clk); #2;
        adj_in = a; det_in = 32'h40400000; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk); #1;
            if (tags_q.size() - tb0 >= 6) hit = 1;
        end
        chk("reach element 5", hit, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrun rst busy", busy, 0);
        chk("midrun rst done", done, 0);
        chk("midrun rst req_valid", div_req_valid, 0);
        chk("midrun rst singular", singular, 0);
        chk("midrun rst inv_out", inv_out, '0);
        #4 rst_n = 1'b1;
        run("after reset", a, 32'h40400000, 3, 0, 0, 0, 0, 0, 66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
